scnn_pe_cp: RTL
===============

# scnn_pe_cp

Parametrised sparse cartesian-product processing element, the successor to the fixed 4x4 SCNN PE. It latches one job of compressed (value, index) input activations and weights. It multiplies every non-zero input against every non-zero weight on an F x I multiplier array, walking all input-group/weight-group pairs. Each product is scattered into a local accumulator bank at output coordinate ip_idx - wt_idx. It sits between the compressed-operand fetch logic and the output-halo/ReLU stage.

## Interface
- DATA_W, 16, activation/weight width, signed two's complement
- ACC_W, 32, accumulator width
- F, 4, weights per group (multiplier array rows)
- I, 4, inputs per group (multiplier array columns)
- MAX_NZ, 16, max non-zeros per operand vector
- IDX_W, 5, uncompressed index / length width
- ACC_DEPTH, 16, accumulator entries (max output length)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled only in IDLE
- ip_len  in  IDX_W  uncompressed input length
- wt_len  in  IDX_W  uncompressed filter length
- comp_ips  in  MAX_NZ*DATA_W  compressed input values, entry n at [n*DATA_W +: DATA_W]
- comp_ip_idx  in  MAX_NZ*IDX_W  original indices of input values
- num_nz_ips  in  $clog2(MAX_NZ+1)  valid input entries
- comp_wts  in  MAX_NZ*DATA_W  compressed weight values
- comp_wt_idx  in  MAX_NZ*IDX_W  original indices of weights
- num_nz_wts  in  $clog2(MAX_NZ+1)  valid weight entries
- busy  out  1  high from cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse, conv_out final
- conv_out  out  ACC_DEPTH*ACC_W  accumulator bank, entry o at [o*ACC_W +: ACC_W]

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch all operand ports, lengths and counts into internal registers; inputs are don't-care afterwards.
  - Clear every accumulator to 0 and zero ip_ptr/wt_ptr.
  - Go to RUN, or go directly to DONE if either count is 0.
- RUN: each cycle issue group (ip_ptr, wt_ptr).
  - Lanes with ip_ptr+j >= num_nz_ips or wt_ptr+k >= num_nz_wts are invalid and contribute nothing.
  - If wt_ptr+F < num_nz_wts: wt_ptr += F.
  - Else: wt_ptr = 0 and ip_ptr += I.
  - The issue with ip_ptr+I >= num_nz_ips and wt_ptr+F >= num_nz_wts is last; go to DRAIN.
  - Issue count G = ceil(nip/I) * ceil(nwt/F).
- DRAIN: 2 cycles to flush the pipeline, then DONE.
- DONE: done=1, busy=1 for one cycle, then IDLE.
- Pipeline:
  - S1: register selected values, indices and lane-valid.
  - S2: register F*I signed products plus coordinates.
  - S3: accumulate.
- Coordinate and scatter:
  - o = ip_idx - wt_idx, signed. out_len = ip_len - wt_len + 1.
  - A product is kept iff valid, 0 <= o < out_len and o < ACC_DEPTH; otherwise it is dropped.
  - If wt_len > ip_len, every product is dropped.
  - Multiple products hitting the same o in one cycle are all summed into that entry in the same cycle; none is lost.
- Arithmetic:
  - DATA_W x DATA_W signed product is 2*DATA_W wide, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W with no saturation.
- Indices need not be sorted; the result is order-independent.
- conv_out holds after done until the next accepted start clears it.
- start while busy is ignored and leaves no pending request.

## Timing
- Reset, asynchronous: state=IDLE, busy=0, done=0, all accumulators and pointers 0, pipeline valids 0.
- Reset mid-job aborts the job: no done is produced and conv_out reads 0.
- start accepted at edge of cycle 0:
  - Normal job: RUN occupies cycles 1..G, DRAIN G+1..G+2, done in cycle G+3.
  - Either count 0: done in cycle 1, conv_out all 0.
- Last accumulation lands at the end of cycle G+2; conv_out is final when done is high.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE); it is not accepted during the DONE cycle itself.

## Test plan
- Dense input, defaults:
  - Stimulus: ip_len=6, ips 1..6 at idx 0..5; wt_len=3, wts 1,1,1 at idx 0..2.
  - Response: conv_out[0..3]=6,9,12,15, rest 0; G=2, done in cycle 5.
- Sparse with same-cycle conflict and drop:
  - Stimulus: ip_len=4, ips {5@2, -2@3}; wt_len=2, wts {3@0, 4@1}.
  - Response: conv_out[1]=20, conv_out[2]=7, o=3 product dropped, all others 0.
- Wrap:
  - Stimulus: ip_len=3, wt_len=3, ips {-32768@1, -32768@2}, wts {-32768@1, -32768@2}.
  - Response: conv_out[0]=32'h8000_0000 (two products of 2^30), others 0.
- Multi-group:
  - Stimulus: ip_len=16, 16 ips of 1 at idx 0..15; wt_len=9, 9 wts of 1 at idx 0..8.
  - Response: conv_out[0..7]=9, [8..15]=0; G=12, done in cycle 15.
- Zero count after a prior job:
  - Stimulus: run the dense-input job, then start with num_nz_wts=0.
  - Response: done in cycle 1, conv_out all 0.
  - Also: wt_len > ip_len with non-zero operands -> done in cycle G+3, all 0.
- Control:
  - Stimulus: multi-group job, start re-pulsed in cycle 5.
  - Response: the re-pulse is ignored; done only in cycle 15.
  - Stimulus: rst_n low in cycle 8 of a repeated job.
  - Response: busy and done drop immediately, conv_out is 0, no done until a new start.

Source files
------------

// File: rtl/scnn_pe_cp.sv
// Sparse cartesian-product PE: multiplies every latched non-zero input by every non-zero weight, scatters to ip_idx - wt_idx.
// Latency: G issue cycles, 2 drain cycles, then a one-cycle done pulse (G+3 cycles after the accepting edge).
// Backpressure: none; start is only sampled in IDLE and is dropped while busy.
module scnn_pe_cp #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int F         = 4,
    parameter int I         = 4,
    parameter int MAX_NZ    = 16,
    parameter int IDX_W     = 5,
    parameter int ACC_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [IDX_W-1:0]              ip_len,
    input  logic [IDX_W-1:0]              wt_len,
    input  logic [MAX_NZ*DATA_W-1:0]      comp_ips,
    input  logic [MAX_NZ*IDX_W-1:0]       comp_ip_idx,
    input  logic [$clog2(MAX_NZ+1)-1:0]   num_nz_ips,
    input  logic [MAX_NZ*DATA_W-1:0]      comp_wts,
    input  logic [MAX_NZ*IDX_W-1:0]       comp_wt_idx,
    input  logic [$clog2(MAX_NZ+1)-1:0]   num_nz_wts,
    output logic                          busy,
    output logic                          done,
    output logic [ACC_DEPTH*ACC_W-1:0]    conv_out
);
    localparam int CNT_W  = $clog2(MAX_NZ + 1);
    localparam int PTR_W  = CNT_W + 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int O_W    = IDX_W + 2;
    localparam int AIDX_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;
    logic   drain_cnt;
    logic   accept, issue, last_issue, zero_job;

    logic [DATA_W-1:0]     ip_val_q [MAX_NZ];
    logic [IDX_W-1:0]      ip_idx_q [MAX_NZ];
    logic [DATA_W-1:0]     wt_val_q [MAX_NZ];
    logic [IDX_W-1:0]      wt_idx_q [MAX_NZ];
    logic [CNT_W-1:0]      nip_q, nwt_q;
    logic signed [O_W-1:0] out_len_q;

    logic [PTR_W-1:0] ip_ptr, wt_ptr;
    logic             ip_end, wt_end;

    assign accept   = (state == S_IDLE) && start;
    assign zero_job = (num_nz_ips == '0) || (num_nz_wts == '0);
    assign issue    = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = zero_job ? S_DONE : S_RUN;
            end
            S_RUN:   if (last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 drain_cnt <= 1'b0;
        else if (state == S_DRAIN)  drain_cnt <= ~drain_cnt;
        else                        drain_cnt <= 1'b0;
    end

    // Operands are captured once so the fetch side may move on immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < MAX_NZ; n++) begin
                ip_val_q[n] <= '0;
                ip_idx_q[n] <= '0;
                wt_val_q[n] <= '0;
                wt_idx_q[n] <= '0;
            end
            nip_q     <= '0;
            nwt_q     <= '0;
            out_len_q <= '0;
        end else if (accept) begin
            for (int n = 0; n < MAX_NZ; n++) begin
                ip_val_q[n] <= comp_ips[n*DATA_W +: DATA_W];
                ip_idx_q[n] <= comp_ip_idx[n*IDX_W +: IDX_W];
                wt_val_q[n] <= comp_wts[n*DATA_W +: DATA_W];
                wt_idx_q[n] <= comp_wt_idx[n*IDX_W +: IDX_W];
            end
            nip_q     <= num_nz_ips;
            nwt_q     <= num_nz_wts;
            out_len_q <= $signed({2'b00, ip_len}) - $signed({2'b00, wt_len}) + O_W'(1);
        end
    end

    // Pointers carry two spare bits so ptr + I/F never wraps on the final step.
    assign wt_end     = (wt_ptr + PTR_W'(F)) >= PTR_W'(nwt_q);
    assign ip_end     = (ip_ptr + PTR_W'(I)) >= PTR_W'(nip_q);
    assign last_issue = ip_end && wt_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_ptr <= '0;
            wt_ptr <= '0;
        end else if (accept) begin
            ip_ptr <= '0;
            wt_ptr <= '0;
        end else if (issue) begin
            if (!wt_end) begin
                wt_ptr <= wt_ptr + PTR_W'(F);
            end else begin
                wt_ptr <= '0;
                ip_ptr <= ip_ptr + PTR_W'(I);
            end
        end
    end

    // S1: operand selection for the current group pair.
    logic [PTR_W-1:0]  ip_pos     [I];
    logic [PTR_W-1:0]  wt_pos     [F];
    logic [DATA_W-1:0] ip_sel_val [I];
    logic [IDX_W-1:0]  ip_sel_idx [I];
    logic              ip_sel_vld [I];
    logic [DATA_W-1:0] wt_sel_val [F];
    logic [IDX_W-1:0]  wt_sel_idx [F];
    logic              wt_sel_vld [F];

    always_comb begin
        for (int j = 0; j < I; j++) begin
            ip_pos[j]     = ip_ptr + PTR_W'(j);
            ip_sel_vld[j] = issue && (ip_pos[j] < PTR_W'(nip_q)) && (ip_pos[j] < PTR_W'(MAX_NZ));
            ip_sel_val[j] = '0;
            ip_sel_idx[j] = '0;
            for (int n = 0; n < MAX_NZ; n++) begin
                if (ip_pos[j] == PTR_W'(n)) begin
                    ip_sel_val[j] = ip_val_q[n];
                    ip_sel_idx[j] = ip_idx_q[n];
                end
            end
        end
        for (int k = 0; k < F; k++) begin
            wt_pos[k]     = wt_ptr + PTR_W'(k);
            wt_sel_vld[k] = issue && (wt_pos[k] < PTR_W'(nwt_q)) && (wt_pos[k] < PTR_W'(MAX_NZ));
            wt_sel_val[k] = '0;
            wt_sel_idx[k] = '0;
            for (int n = 0; n < MAX_NZ; n++) begin
                if (wt_pos[k] == PTR_W'(n)) begin
                    wt_sel_val[k] = wt_val_q[n];
                    wt_sel_idx[k] = wt_idx_q[n];
                end
            end
        end
    end

    logic [DATA_W-1:0] s1_ip_val [I];
    logic [IDX_W-1:0]  s1_ip_idx [I];
    logic              s1_ip_vld [I];
    logic [DATA_W-1:0] s1_wt_val [F];
    logic [IDX_W-1:0]  s1_wt_idx [F];
    logic              s1_wt_vld [F];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < I; j++) begin
                s1_ip_val[j] <= '0;
                s1_ip_idx[j] <= '0;
                s1_ip_vld[j] <= 1'b0;
            end
            for (int k = 0; k < F; k++) begin
                s1_wt_val[k] <= '0;
                s1_wt_idx[k] <= '0;
                s1_wt_vld[k] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < I; j++) begin
                s1_ip_val[j] <= ip_sel_val[j];
                s1_ip_idx[j] <= ip_sel_idx[j];
                s1_ip_vld[j] <= ip_sel_vld[j];
            end
            for (int k = 0; k < F; k++) begin
                s1_wt_val[k] <= wt_sel_val[k];
                s1_wt_idx[k] <= wt_sel_idx[k];
                s1_wt_vld[k] <= wt_sel_vld[k];
            end
        end
    end

    // S2: F x I products, output coordinate and keep decision.
    logic signed [O_W-1:0]    o_c    [F][I];
    logic signed [PROD_W-1:0] prod_c [F][I];
    logic                     keep_c [F][I];

    always_comb begin
        for (int k = 0; k < F; k++) begin
            for (int j = 0; j < I; j++) begin
                o_c[k][j]    = $signed({2'b00, s1_ip_idx[j]}) - $signed({2'b00, s1_wt_idx[k]});
                prod_c[k][j] = PROD_W'($signed(s1_ip_val[j])) * PROD_W'($signed(s1_wt_val[k]));
                keep_c[k][j] = s1_ip_vld[j] && s1_wt_vld[k] && !o_c[k][j][O_W-1]
                               && (o_c[k][j] < out_len_q) && (int'(o_c[k][j]) < ACC_DEPTH);
            end
        end
    end

    logic signed [PROD_W-1:0] s2_prod [F][I];
    logic [AIDX_W-1:0]        s2_o    [F][I];
    logic                     s2_vld  [F][I];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < F; k++) begin
                for (int j = 0; j < I; j++) begin
                    s2_prod[k][j] <= '0;
                    s2_o[k][j]    <= '0;
                    s2_vld[k][j]  <= 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < F; k++) begin
                for (int j = 0; j < I; j++) begin
                    s2_prod[k][j] <= prod_c[k][j];
                    s2_o[k][j]    <= AIDX_W'(o_c[k][j]);
                    s2_vld[k][j]  <= keep_c[k][j];
                end
            end
        end
    end

    // S3: each entry sums every product aimed at it this cycle, so collisions are never lost.
    logic [ACC_W-1:0] acc     [ACC_DEPTH];
    logic [ACC_W-1:0] acc_add [ACC_DEPTH];

    always_comb begin
        for (int e = 0; e < ACC_DEPTH; e++) begin
            acc_add[e] = '0;
            for (int k = 0; k < F; k++) begin
                for (int j = 0; j < I; j++) begin
                    if (s2_vld[k][j] && (s2_o[k][j] == AIDX_W'(e))) begin
                        acc_add[e] = acc_add[e] + ACC_W'(s2_prod[k][j]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ACC_DEPTH; e++) acc[e] <= '0;
        end else if (accept) begin
            for (int e = 0; e < ACC_DEPTH; e++) acc[e] <= '0;
        end else begin
            for (int e = 0; e < ACC_DEPTH; e++) acc[e] <= acc[e] + acc_add[e];
        end
    end

    always_comb begin
        conv_out = '0;
        for (int e = 0; e < ACC_DEPTH; e++) conv_out[e*ACC_W +: ACC_W] = acc[e];
    end

endmodule
